// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C constants and target FSM state encoding
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: synchronises SCL/SDA and emits registered edge, START and STOP pulses
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_h, sda_h, scl_n, sda_n, sda_rise, sda_fall;
  assign scl_n = scl_s[SYNC_STAGES-1];
  assign sda_n = sda_s[SYNC_STAGES-1];
  assign sda_rise = sda_n & ~sda_h;
  assign sda_fall = ~sda_n & sda_h;
  // idle bus is high, so reset to 1 to avoid spurious edges leaving reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
      sda <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start <= 1'b0;
      stop <= 1'b0;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl_i};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda_i};
      scl_h <= scl_n;
      sda_h <= sda_n;
      sda <= sda_n;
      scl_rise <= scl_n & ~scl_h;
      scl_fall <= ~scl_n & scl_h;
      start <= sda_fall & scl_n & scl_h;
      stop <= sda_rise & scl_n & scl_h;
    end
  end
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampled I2C target serving a register file with auto-incrementing pointer
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int SYNC_STAGES = 2,
  parameter logic [I2C_BYTE_W-1:0] RESET_VAL = 8'h55,
  localparam int PW = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic [I2C_ADDR_W-1:0] own_addr,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [I2C_BYTE_W-1:0] data_out,
  output logic busy
);
  state_t state, state_n;
  logic sda, scl_rise, scl_fall, start, stop, match, rw, full;
  logic [3:0] bitcnt;
  logic [6:0] sh, rd_sh;
  logic [I2C_BYTE_W-1:0] rx_byte, rd_cur;
  logic [PW-1:0] ptr;
  logic [I2C_BYTE_W-1:0] regs [NUM_REGS];
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign rx_byte = {sh, sda};
  assign rd_cur = regs[ptr];
  assign full = bitcnt == 4'd8;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else if (start) state_n = ADDR;
    else case (state)
      ADDR: if (scl_fall && full) state_n = match ? ADDR_ACK : WAIT_STOP;
      ADDR_ACK: if (scl_fall) state_n = rw ? RDATA : PTR;
      PTR: if (scl_fall && full) state_n = PTR_ACK;
      PTR_ACK, WDATA_ACK: if (scl_fall) state_n = WDATA;
      WDATA: if (scl_fall && full) state_n = WDATA_ACK;
      RDATA: if (scl_fall && full) state_n = RD_ACK;
      RD_ACK: state_n = (scl_rise && sda != ACK) ? WAIT_STOP : scl_fall ? RDATA : RD_ACK;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      data_out <= '0;
      busy <= 1'b0;
      ptr <= '0;
      bitcnt <= '0;
      sh <= '0;
      rd_sh <= '0;
      match <= 1'b0;
      rw <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_stb <= 1'b0;
      if (stop) begin
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (start) begin
        sda_oe <= 1'b0;
        bitcnt <= '0;
      end else case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && !full) begin
            sh <= rx_byte[6:0];
            bitcnt <= bitcnt + 4'd1;
            if (state == ADDR && bitcnt == 4'd6) match <= rx_byte[6:0] == own_addr;
            if (state == ADDR && bitcnt == 4'd7) rw <= sda;
            if (state == PTR && bitcnt == 4'd7) ptr <= rx_byte[PW-1:0];
            if (state == WDATA && bitcnt == 4'd7) begin
              regs[ptr] <= rx_byte;
              wr_stb <= 1'b1;
              wr_addr <= ptr;
              data_out <= rx_byte;
              ptr <= ptr + PW'(1);
            end
          end
          if (scl_fall && full) begin
            sda_oe <= state != ADDR || match;
            if (state == ADDR) busy <= match;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bitcnt <= '0;
          sda_oe <= rw & ~rd_cur[7];
          rd_sh <= rd_cur[6:0];
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          bitcnt <= '0;
          sda_oe <= 1'b0;
        end
        // read pointer advances once the byte is fully shifted out, before the master's ACK/NACK
        RDATA: begin
          if (scl_rise && !full) bitcnt <= bitcnt + 4'd1;
          if (scl_fall) begin
            sda_oe <= full ? 1'b0 : ~rd_sh[6];
            rd_sh <= {rd_sh[5:0], 1'b0};
            if (full) ptr <= ptr + PW'(1);
          end
        end
        RD_ACK: if (scl_rise && sda == NACK) busy <= 1'b0;
          else if (scl_fall) begin
            bitcnt <= '0;
            sda_oe <= ~rd_cur[7];
            rd_sh <= rd_cur[6:0];
          end
        default: sda_oe <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed bus-level bench with an open-drain master model and write log
module tb_i2c_target_regfile;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic [6:0] own_addr = 7'h42;
  logic sda_oe, wr_stb, busy;
  logic [3:0] wr_addr;
  logic [7:0] data_out;
  logic sda_line;
  int tests = 0, fails = 0, oe_cnt = 0, base, oe0;
  logic [11:0] wlog[$];
  logic a;
  logic [7:0] d;
  typedef struct {
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [3:0] exp_addr;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[6];
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target_regfile dut (
    .clk(clk), .rst(rst), .own_addr(own_addr), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .data_out(data_out), .busy(busy)
  );
  always @(negedge clk) begin
    if (wr_stb) wlog.push_back({wr_addr, data_out});
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic logic [11:0] ent(input int i);
    return i < wlog.size() ? wlog[i] : 12'hxxx;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic q();
    repeat (8) @(negedge clk);
  endtask
  task automatic start_c();
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    sda_m = 1'b0; q();
    scl = 1'b0; q();
  endtask
  task automatic stop_c();
    sda_m = 1'b0; q();
    scl = 1'b1; q();
    sda_m = 1'b1; q();
  endtask
  task automatic bit_w(input logic b);
    sda_m = b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask
  task automatic bit_r(output logic b);
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    b = sda_line; q();
    scl = 1'b0; q();
  endtask
  task automatic wbyte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    bit_r(ack);
  endtask
  task automatic rbyte(input logic ack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_r(v[i]);
    bit_w(ack);
  endtask
  initial begin
    vecs[0] = '{8'h05, 8'h00, 4'h5, 8'h00};
    vecs[1] = '{8'h06, 8'hFF, 4'h6, 8'hFF};
    vecs[2] = '{8'h1A, 8'h5C, 4'hA, 8'h5C};
    vecs[3] = '{8'hFF, 8'h3C, 4'hF, 8'h3C};
    vecs[4] = '{8'h10, 8'hC3, 4'h0, 8'hC3};
    vecs[5] = '{8'h09, 8'h81, 4'h9, 8'h81};
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; q();
    base = wlog.size();
    start_c();
    wbyte(8'h84, a); check("t1_addr_ack", a, 0);
    check("t1_busy", busy, 1);
    wbyte(8'h03, a); check("t1_ptr_ack", a, 0);
    wbyte(8'hA5, a); check("t1_d0_ack", a, 0);
    wbyte(8'h5A, a); check("t1_d1_ack", a, 0);
    stop_c(); q();
    check("t1_wr_count", wlog.size() - base, 2);
    check("t1_wr0", ent(base), {4'h3, 8'hA5});
    check("t1_wr1", ent(base + 1), {4'h4, 8'h5A});
    check("t1_data_out", data_out, 8'h5A);
    check("t1_busy_stop", busy, 0);
    base = wlog.size();
    start_c(); wbyte(8'h84, a); wbyte(8'h03, a);
    start_c(); wbyte(8'h85, a); check("t2_raddr_ack", a, 0);
    rbyte(1'b0, d); check("t2_rd0", d, 8'hA5);
    rbyte(1'b0, d); check("t2_rd1", d, 8'h5A);
    check("t2_busy_mid", busy, 1);
    rbyte(1'b1, d); check("t2_rd2", d, 8'h55);
    check("t2_busy_nack", busy, 0);
    stop_c(); q();
    check("t2_no_wr", wlog.size() - base, 0);
    base = wlog.size();
    start_c(); wbyte(8'h84, a); wbyte(8'h0F, a); wbyte(8'h11, a); wbyte(8'h22, a); stop_c(); q();
    check("t3_wr0", ent(base), {4'hF, 8'h11});
    check("t3_wr1", ent(base + 1), {4'h0, 8'h22});
    start_c(); wbyte(8'h84, a); wbyte(8'h0F, a);
    start_c(); wbyte(8'h85, a);
    rbyte(1'b0, d); check("t3_rd15", d, 8'h11);
    rbyte(1'b1, d); check("t3_rd0", d, 8'h22);
    stop_c(); q();
    base = wlog.size();
    oe0 = oe_cnt;
    start_c();
    wbyte(8'h86, a); check("t4_addr_nack", a, 1);
    wbyte(8'h01, a); check("t4_b1_nack", a, 1);
    wbyte(8'h77, a); check("t4_b2_nack", a, 1);
    check("t4_busy", busy, 0);
    stop_c(); q();
    check("t4_oe_never", oe_cnt - oe0, 0);
    check("t4_no_wr", wlog.size() - base, 0);
    base = wlog.size();
    start_c(); wbyte(8'h84, a); wbyte(8'h02, a);
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    start_c(); wbyte(8'h85, a); check("t5_raddr_ack", a, 0);
    rbyte(1'b1, d); check("t5_reg2", d, 8'h55);
    stop_c(); q();
    check("t5_no_wr", wlog.size() - base, 0);
    start_c(); wbyte(8'h84, a); wbyte(8'h01, a);
    start_c(); wbyte(8'h85, a);
    check("t6_driving", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_oe", sda_oe, 0);
    check("t6_rst_data_out", data_out, 0);
    check("t6_rst_busy", busy, 0);
    q();
    start_c(); wbyte(8'h85, a); check("t6_post_ack", a, 0);
    rbyte(1'b1, d); check("t6_reg0_reset", d, 8'h55);
    stop_c(); q();
    start_c(); wbyte(8'h84, a); wbyte(8'h03, a);
    start_c(); wbyte(8'h85, a);
    rbyte(1'b1, d); check("t6_reg3_reset", d, 8'h55);
    stop_c(); q();
    for (int i = 0; i < 6; i++) begin
      base = wlog.size();
      start_c(); wbyte(8'h84, a); wbyte(vecs[i].ptr, a); wbyte(vecs[i].wdata, a);
      check($sformatf("vec%0d_ack", i), a, 0);
      stop_c(); q();
      check($sformatf("vec%0d_wr_count", i), wlog.size() - base, 1);
      check($sformatf("vec%0d_wr", i), ent(base), {vecs[i].exp_addr, vecs[i].wdata});
      start_c(); wbyte(8'h84, a); wbyte(vecs[i].ptr, a);
      start_c(); wbyte(8'h85, a);
      rbyte(1'b1, d);
      stop_c(); q();
      check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
